// File: rtl/peripheral_msi_slave_memory_ahb3.sv
// peripheral_msi_slave_memory_ahb3
// AHB3-Lite responder backed by a word-addressed RAM. It inserts a fixed number
// of wait states before each OKAY data phase and supports HSIZE byte-lane writes.
// Read data is registered when the data phase starts. A write committing on that
// same edge is merged in, so back-to-back write/read sees the new bytes.
// Define PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN to answer illegal transfers
// (oversized or misaligned) with the two-cycle ERROR response. Without it, such
// transfers are aligned down, clamped to a full word and completed as OKAY.
module peripheral_msi_slave_memory_ahb3 #(
   parameter int PLEN        = 64,
   parameter int XLEN        = 64,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            HSEL,
   input  logic [PLEN-1:0] HADDR,
   input  logic [XLEN-1:0] HWDATA,
   output logic [XLEN-1:0] HRDATA,
   input  logic            HWRITE,
   input  logic [2:0]      HSIZE,
   input  logic [2:0]      HBURST,
   input  logic [3:0]      HPROT,
   input  logic [1:0]      HTRANS,
   input  logic            HMASTLOCK,
   output logic            HREADYOUT,
   input  logic            HREADY,
   output logic            HRESP
);

   localparam int NB  = XLEN / 8;
   localparam int LSB = $clog2(NB);
   localparam int AW  = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

   state_t          state, state_d, state_acc;
   logic [3:0]      cnt, cnt_d;

   // Captured address phase
   logic [AW-1:0]   idx_q;
   logic [NB-1:0]   mask_q;
   logic            write_q;
   logic [XLEN-1:0] rdata_q;

   // Address-phase decode
   logic            acc, take;
   logic [AW-1:0]   idx_in;
   logic [LSB-1:0]  low_raw, low_eff;
   logic [2:0]      size_eff;
   logic [NB-1:0]   mask_in;
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
   logic            legal;
`endif

   // Read path
   logic            commit, rd_from_addr, rd_from_wait, rd_load;
   logic [AW-1:0]   rd_idx;
   logic [XLEN-1:0] rd_word;

   logic [XLEN-1:0] mem [DEPTH];

   // Burst type, protection, lock and the aliased upper address bits have no effect here.
   logic unused;
   assign unused = ^{HBURST, HPROT, HMASTLOCK, HADDR[PLEN-1:AW+LSB]};

   assign acc     = HSEL & HREADY & HTRANS[1];
   // Only accept a new address phase while our own previous data phase is completing.
   assign take    = acc & HREADYOUT;
   assign idx_in  = HADDR[AW+LSB-1:LSB];
   assign low_raw = HADDR[LSB-1:0];
   assign commit  = (state == ST_DATA) && write_q;

   // Decode size, alignment and byte-lane mask of the transfer on the bus.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      size_eff = (HSIZE > 3'(LSB)) ? 3'(LSB) : HSIZE;
      low_eff  = low_raw & ~((LSB'(1) << size_eff) - LSB'(1));
      mask_in  = '0;
      for (int i = 0; i < NB; i++)
         mask_in[i] = (i >= int'(low_eff)) && (i < int'(low_eff) + (1 << size_eff));
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
      legal = (HSIZE <= 3'(LSB)) && (low_raw == low_eff);
`endif
   end

   // Pick the state that a newly accepted address phase leads to.
   always_comb begin
      state_acc = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
      if (!legal) state_acc = ST_ERR1;
`endif
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         ST_IDLE: state_d = take ? state_acc : ST_IDLE;
         ST_WAIT: begin
            if (cnt == 4'd0) state_d = ST_DATA;
            else             cnt_d   = cnt - 4'd1;
         end
         ST_DATA: state_d = take ? state_acc : ST_IDLE;
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = take ? state_acc : ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_WAIT && state != ST_WAIT) cnt_d = WS_LOAD;
   end

   // Handshake outputs are decoded straight from the state, so reset reaches them at once.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         ST_WAIT: HREADYOUT = 1'b0;
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         ST_ERR2: HRESP = 1'b1;
`endif
         default: ;
      endcase
   end

   // Read word fetched as the data phase starts, with the committing write merged in.
   always_comb begin
      rd_from_addr = take && (state_acc == ST_DATA) && !HWRITE;
      rd_from_wait = (state == ST_WAIT) && (cnt == 4'd0) && !write_q;
      rd_load      = rd_from_addr | rd_from_wait;
      rd_idx       = rd_from_wait ? idx_q : idx_in;
      rd_word      = mem[rd_idx];
      if (commit && (rd_idx == idx_q)) begin
         for (int i = 0; i < NB; i++)
            if (mask_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
   end

   assign HRDATA = ((state == ST_DATA) && !write_q) ? rdata_q : '0;

   // State, counter and captured address-phase registers.
   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         mask_q  <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (take) begin
            idx_q   <= idx_in;
            mask_q  <= mask_in;
            write_q <= HWRITE;
         end
         if (rd_load) rdata_q <= rd_word;
      end
   end

   // Byte-lane write commit at the edge that ends a write data phase.
   // NOTE: the RAM array is deliberately left out of reset; its contents survive HRESETn.
   always_ff @(posedge HCLK) begin
      if (commit) begin
         for (int i = 0; i < NB; i++)
            if (mask_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_peripheral_msi_slave_memory_ahb3.sv
// Testbench for peripheral_msi_slave_memory_ahb3. Two instances share the bus:
// dut0 with no wait states and dut1 with three. Table-driven single transfers,
// then hand-written sequences for pipelining, IDLE/BUSY, illegal transfers and
// reset in the middle of a wait phase.
module tb_peripheral_msi_slave_memory_ahb3;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel0, hsel1, cur, hready_kill;
   logic [63:0] haddr, hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [2:0]  hburst = 3'd0;
   logic [3:0]  hprot = 4'd0;
   logic        hmastlock = 1'b0;
   logic [63:0] hrdata0, hrdata1, hrdata_cur;
   logic        hreadyout0, hreadyout1, hready0, hready1, hreadyout_cur;
   logic        hresp0, hresp1, hresp_cur;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign hready0       = hreadyout0;
   assign hready1       = hreadyout1 & ~hready_kill;
   assign hrdata_cur    = cur ? hrdata1 : hrdata0;
   assign hreadyout_cur = cur ? hreadyout1 : hreadyout0;
   assign hresp_cur     = cur ? hresp1 : hresp0;

   peripheral_msi_slave_memory_ahb3 #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADYOUT(hreadyout0), .HREADY(hready0),
      .HRESP(hresp0)
   );

   peripheral_msi_slave_memory_ahb3 #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAIT_STATES(3)) u_dut1 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADYOUT(hreadyout1), .HREADY(hready1),
      .HRESP(hresp1)
   );

   typedef struct {
      logic        dut;
      logic        wr;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One non-pipelined transfer; returns data/response of the completing cycle.
   task automatic xfer(input logic d, input logic wr, input logic [63:0] addr,
                       input logic [2:0] size, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic resp_first,
                       output logic resp_last, output int waits);
      @(posedge clk); #1;
      cur = d; hsel0 = ~d; hsel1 = d;
      htrans = T_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
      @(posedge clk); #1;
      hsel0 = 1'b0; hsel1 = 1'b0; htrans = T_IDLE; hwdata = wdata;
      waits = 0;
      @(negedge clk);
      resp_first = hresp_cur;
      while (hreadyout_cur !== 1'b1 && waits < 40) begin
         waits++;
         @(negedge clk);
      end
      rdata     = hrdata_cur;
      resp_last = hresp_cur;
   endtask

   // Write immediately followed by a read whose address phase overlaps the write data phase.
   task automatic pipe_wr_rd(input string name, input logic [63:0] waddr, input logic [2:0] wsize,
                             input logic [63:0] wdata, input logic [63:0] raddr,
                             input logic [63:0] exp);
      @(posedge clk); #1;
      cur = 1'b0; hsel0 = 1'b1; hsel1 = 1'b0;
      htrans = T_NONSEQ; haddr = waddr; hwrite = 1'b1; hsize = wsize;
      @(posedge clk); #1;
      hwdata = wdata; haddr = raddr; hwrite = 1'b0; hsize = 3'd3;
      @(negedge clk);
      check({name, "_wr_ready"}, 64'(hreadyout0), 64'd1);
      @(posedge clk); #1;
      hsel0 = 1'b0; htrans = T_IDLE;
      @(negedge clk);
      check({name, "_rd_ready"}, 64'(hreadyout0), 64'd1);
      check({name, "_rd_data"}, hrdata0, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] rd;
      logic        rf, rl;
      int          w;

      //         dut   wr    addr       size  wdata                   expected rdata
      vecs[0]  = '{1'b0, 1'b1, 64'h10,  3'd3, 64'h1122334455667788, 64'h0};
      vecs[1]  = '{1'b0, 1'b0, 64'h10,  3'd3, 64'h0,                64'h1122334455667788};
      vecs[2]  = '{1'b0, 1'b1, 64'h13,  3'd0, 64'h00000000AB000000, 64'h0};
      vecs[3]  = '{1'b0, 1'b0, 64'h10,  3'd3, 64'h0,                64'h11223344AB667788};
      vecs[4]  = '{1'b0, 1'b1, 64'h14,  3'd2, 64'h99AABBCC00000000, 64'h0};
      vecs[5]  = '{1'b0, 1'b0, 64'h10,  3'd3, 64'h0,                64'h99AABBCCAB667788};
      vecs[6]  = '{1'b0, 1'b1, 64'h18,  3'd3, 64'h0,                64'h0};
      vecs[7]  = '{1'b0, 1'b1, 64'h1C,  3'd1, 64'h0000BEEF00000000, 64'h0};
      vecs[8]  = '{1'b0, 1'b0, 64'h818, 3'd3, 64'h0,                64'h0000BEEF00000000};
      vecs[9]  = '{1'b0, 1'b1, 64'h7F8, 3'd3, 64'hFEEDFACE0BADF00D, 64'h0};
      vecs[10] = '{1'b0, 1'b0, 64'h7F8, 3'd3, 64'h0,                64'hFEEDFACE0BADF00D};
      vecs[11] = '{1'b1, 1'b1, 64'h08,  3'd3, 64'h0123456789ABCDEF, 64'h0};
      vecs[12] = '{1'b1, 1'b0, 64'h08,  3'd3, 64'h0,                64'h0123456789ABCDEF};
      vecs[13] = '{1'b1, 1'b1, 64'h0E,  3'd1, 64'h5566000000000000, 64'h0};
      vecs[14] = '{1'b1, 1'b0, 64'h08,  3'd3, 64'h0,                64'h5566456789ABCDEF};

      rst_n = 1'b0; cur = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; hready_kill = 1'b0;
      haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'd0; htrans = T_IDLE;
      #1;
      check("rst_hreadyout0", 64'(hreadyout0), 64'd1);
      check("rst_hresp0",     64'(hresp0),     64'd0);
      check("rst_hrdata0",    hrdata0,         64'd0);
      check("rst_hreadyout1", 64'(hreadyout1), 64'd1);
      check("rst_hrdata1",    hrdata1,         64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rf, rl, w);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         check($sformatf("vec%0d_resp", i), 64'(rl), 64'd0);
         check($sformatf("vec%0d_waits", i), 64'(w), vecs[i].dut ? 64'd3 : 64'd0);
      end

      // Read-after-write bypass, full word and partial lanes over old data.
      pipe_wr_rd("bypass_full", 64'h20, 3'd3, 64'h000000000000CAFE, 64'h20, 64'h000000000000CAFE);
      xfer(1'b0, 1'b1, 64'h28, 3'd3, 64'h1111111111111111, rd, rf, rl, w);
      pipe_wr_rd("bypass_lanes", 64'h2A, 3'd1, 64'h00000000BEEF0000, 64'h28, 64'h11111111BEEF1111);

      // IDLE, BUSY and HREADY-low address phases must not start a transfer on dut1.
      @(posedge clk); #1;
      cur = 1'b1; hsel1 = 1'b1; htrans = T_IDLE; haddr = 64'h08; hwrite = 1'b0; hsize = 3'd3;
      @(posedge clk); #1;
      htrans = T_BUSY;
      @(negedge clk);
      check("idle_no_wait", 64'(hreadyout1), 64'd1);
      @(posedge clk); #1;
      htrans = T_NONSEQ; hready_kill = 1'b1;
      @(negedge clk);
      check("busy_no_wait", 64'(hreadyout1), 64'd1);
      @(posedge clk); #1;
      hsel1 = 1'b0; htrans = T_IDLE; hready_kill = 1'b0;
      @(negedge clk);
      check("hready_low_no_wait", 64'(hreadyout1), 64'd1);
      check("hready_low_resp", 64'(hresp1), 64'd0);

      // Illegal transfers on dut0: misaligned word write and oversized write.
      xfer(1'b0, 1'b1, 64'h00, 3'd3, 64'hA5A5A5A55A5A5A5A, rd, rf, rl, w);
      xfer(1'b0, 1'b1, 64'h02, 3'd2, 64'hFFFFFFFFDEADBEEF, rd, rf, rl, w);
      check("misalign_hrdata", rd, 64'd0);
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
      check("misalign_err1_resp", 64'(rf), 64'd1);
      check("misalign_err2_resp", 64'(rl), 64'd1);
      check("misalign_waits", 64'(w), 64'd1);
      xfer(1'b0, 1'b0, 64'h00, 3'd3, 64'h0, rd, rf, rl, w);
      check("misalign_mem", rd, 64'hA5A5A5A55A5A5A5A);
`else
      check("misalign_resp", 64'(rl), 64'd0);
      check("misalign_waits", 64'(w), 64'd0);
      xfer(1'b0, 1'b0, 64'h00, 3'd3, 64'h0, rd, rf, rl, w);
      check("misalign_mem", rd, 64'hA5A5A5A5DEADBEEF);
`endif
      xfer(1'b0, 1'b1, 64'h40, 3'd3, 64'h1111111111111111, rd, rf, rl, w);
      xfer(1'b0, 1'b1, 64'h40, 3'd4, 64'h2222222222222222, rd, rf, rl, w);
`ifdef PERIPHERAL_MSI_SLAVE_MEMORY_AHB3_ERROR_EN
      check("oversize_resp", 64'(rl), 64'd1);
      xfer(1'b0, 1'b0, 64'h40, 3'd3, 64'h0, rd, rf, rl, w);
      check("oversize_mem", rd, 64'h1111111111111111);
`else
      check("oversize_resp", 64'(rl), 64'd0);
      xfer(1'b0, 1'b0, 64'h40, 3'd3, 64'h0, rd, rf, rl, w);
      check("oversize_mem", rd, 64'h2222222222222222);
`endif

      // Reset in the second wait cycle of a dut1 write aborts it without committing.
      xfer(1'b1, 1'b1, 64'h30, 3'd3, 64'h0F0F0F0F0F0F0F0F, rd, rf, rl, w);
      @(posedge clk); #1;
      cur = 1'b1; hsel1 = 1'b1; htrans = T_NONSEQ; haddr = 64'h30; hwrite = 1'b1; hsize = 3'd3;
      @(posedge clk); #1;
      hsel1 = 1'b0; htrans = T_IDLE; hwdata = 64'hF0F0F0F0F0F0F0F0;
      @(negedge clk);
      check("rstwait_first_wait", 64'(hreadyout1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rstwait_hreadyout", 64'(hreadyout1), 64'd1);
      check("rstwait_hresp", 64'(hresp1), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b1, 1'b0, 64'h30, 3'd3, 64'h0, rd, rf, rl, w);
      check("rstwait_mem", rd, 64'h0F0F0F0F0F0F0F0F);
      check("rstwait_read_waits", 64'(w), 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
